// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac -- one neuron's multiply-accumulate stage.
//
// Accepts numInputs beats of signed 8.8 (data, weight) pairs. Each beat adds a
// full-precision 16.16 product into a wide accumulator. The 8.8 bias is then
// added, aligned to 16.16. The sum is arithmetically shifted right by SHIFT and
// saturated to a signed outWidth-bit index for the downstream sigmoid LUT. The
// result is held until the consumer takes it.
//
// Parameters
//   dataWidth  width of the signed 8.8 data, weight and bias
//   numInputs  beats per dot product (1..255)
//   outWidth   width of the signed activation index out_x
//   SHIFT      arithmetic right shift applied to the 16.16 sum
//
// Ports
//   clk        sole clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   a beat is accepted this cycle (high only while accumulating)
//   in_data    signed 8.8 activation
//   in_weight  signed 8.8 weight
//   bias       signed 8.8 bias, sampled in the cycle after the last beat
//   out_valid  out_x holds a result
//   out_ready  downstream accepts out_x
//   out_x      signed, saturated pre-activation index
//   busy       a vector is in progress or a result is pending
//   sat_flag   (only with NEURON_MAC_SAT_FLAG_EN) result was clipped
//
// Build option
//   NEURON_MAC_SAT_FLAG_EN  adds the sat_flag output and its register.
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int dataWidth = 16,
    parameter int numInputs = 2,
    parameter int outWidth  = 8,
    parameter int SHIFT     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [dataWidth-1:0] in_data,
    input  logic [dataWidth-1:0] in_weight,
    input  logic [dataWidth-1:0] bias,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [outWidth-1:0]  out_x,
    output logic                 busy
`ifdef NEURON_MAC_SAT_FLAG_EN
    ,
    output logic                 sat_flag
`endif
);

    localparam int PROD_W = 2 * dataWidth;
    // Eight guard bits: the sum of up to 255 full-scale products cannot wrap.
    localparam int ACC_W  = PROD_W + 8;

    localparam logic [1:0] ST_ACC  = 2'd0;
    localparam logic [1:0] ST_BIAS = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [7:0] LAST_BEAT = 8'(numInputs - 1);

    // Saturation limits of out_x, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-outWidth+1){1'b0}}, {(outWidth-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-outWidth+1){1'b1}}, {(outWidth-1){1'b0}}};

    logic [1:0]                state;
    logic [7:0]                beat_cnt;
    logic signed [ACC_W-1:0]   acc;

    logic                      beat_fire;
    logic signed [PROD_W-1:0]  product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   shifted;
    logic [outWidth-1:0]       sat_x;

    assign in_ready  = (state == ST_ACC);
    assign beat_fire = in_valid && in_ready;
    assign busy      = (state != ST_ACC) || (beat_cnt != 8'd0);

    // 8.8 x 8.8 gives a 16.16 product directly.
    assign product     = $signed(in_data) * $signed(in_weight);
    assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    // The bias is 8.8, so append 8 fraction bits to align it with 16.16.
    assign bias_ext    = {{(ACC_W-dataWidth-8){bias[dataWidth-1]}}, bias, 8'h00};

    // Arithmetic shift on a signed operand rounds toward minus infinity.
    assign shifted = acc >>> SHIFT;

    // NOTE: give every always_comb output a value on every path (here the
    // default first) so that no latch is inferred.
    always_comb begin
        sat_x = shifted[outWidth-1:0];
        if (shifted > SAT_MAX) begin
            sat_x = SAT_MAX[outWidth-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_x = SAT_MIN[outWidth-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            beat_cnt  <= 8'd0;
            acc       <= '0;
            out_x     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (beat_fire) begin
                        acc <= acc + product_ext;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= 8'd0;
                            state    <= ST_BIAS;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                ST_BIAS: begin
                    acc   <= acc + bias_ext;
                    state <= ST_SAT;
                end
                ST_SAT: begin
                    out_x     <= sat_x;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

`ifdef NEURON_MAC_SAT_FLAG_EN
    logic clipped;
    assign clipped = (shifted > SAT_MAX) || (shifted < SAT_MIN);

    // Follows out_valid: loaded with the result and cleared when it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (state == ST_SAT) begin
            sat_flag <= clipped;
        end else if (state == ST_HOLD && out_ready) begin
            sat_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac -- self-checking bench for neuron_mac with default parameters
// (2 beats, 8.8 data, 8-bit index, shift 12). A reference model computes the
// expected index from real-valued dot-product arithmetic. A compare process
// checks out_x against it on every cycle out_valid is high. Directed
// vectors also pin literal results, the latency, hold behaviour and reset.
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_weight;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_x;
    logic        busy;
`ifdef NEURON_MAC_SAT_FLAG_EN
    logic        sat_flag;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int x;
        bit sat;
    } exp_t;

    exp_t expq[$];

    always #5 clk = ~clk;

    neuron_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .busy      (busy)
`ifdef NEURON_MAC_SAT_FLAG_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Dot product in real-number terms: 8.8 values times 8.8 values, plus the
    // 8.8 bias scaled to 16.16. Dividing by 4096 with floor gives the index.
    function automatic exp_t model(input logic [15:0] d0, d1, w0, w1, b);
        longint s;
        exp_t   e;
        s = longint'($signed(d0)) * longint'($signed(w0))
          + longint'($signed(d1)) * longint'($signed(w1))
          + longint'($signed(b)) * 256;
        s = s >>> 12;
        e.sat = 1'b0;
        if (s > 127) begin
            s = 127;
            e.sat = 1'b1;
        end else if (s < -128) begin
            s = -128;
            e.sat = 1'b1;
        end
        e.x = int'(s);
        return e;
    endfunction

    // Compare process: while a result is presented, it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("model_out_x", longint'($signed(out_x)), longint'(expq[0].x));
`ifdef NEURON_MAC_SAT_FLAG_EN
                check("model_sat_flag", longint'(sat_flag), longint'(expq[0].sat));
`endif
                check("in_ready_while_valid", longint'(in_ready), 0);
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    // Present one beat and hold it until the DUT takes it. Returns 1 ns after
    // the accepting edge with in_valid dropped.
    task automatic drive_beat(input logic [15:0] d, input logic [15:0] w);
        int waited = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send a two-beat vector and check latency plus the literal result.
    task automatic send_vec(input string name, input logic [15:0] d0, d1, w0, w1, b,
                            input int lit_x);
        bias = b;
        expq.push_back(model(d0, d1, w0, w1, b));
        drive_beat(d0, w0);
        drive_beat(d1, w1);
        check({name, "_valid_lat0"}, longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check({name, "_valid_lat1"}, longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check({name, "_valid_lat2"}, longint'(out_valid), 1);
        check({name, "_out_x"}, longint'($signed(out_x)), longint'(lit_x));
    endtask

    // Keep the result waiting for hold_cycles with stray in_valid, then take it.
    task automatic take_result(input string name, input int hold_cycles);
        logic [7:0] held;
        held = out_x;
        for (int i = 0; i < hold_cycles; i++) begin
            in_valid  = 1'b1;
            in_data   = 16'h7FFF;
            in_weight = 16'h7FFF;
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, longint'(out_valid), 1);
            check({name, "_hold_x"}, longint'(out_x), longint'(held));
            check({name, "_hold_in_ready"}, longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_taken_valid"}, longint'(out_valid), 0);
        check({name, "_taken_in_ready"}, longint'(in_ready), 1);
        check({name, "_taken_busy"}, longint'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        bias      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_x", longint'(out_x), 0);
        check("rst_busy", longint'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // out_ready with nothing pending has no effect.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_ready_valid", longint'(out_valid), 0);
        check("idle_ready_busy", longint'(busy), 0);

        // 1.0*1.0 + 1.0*1.0 = 2.0 -> 0x20000 >>> 12 = 32
        send_vec("ones", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 32);
        take_result("ones", 5);

        // 1.0*-1.0 twice, bias -1.0 -> -3.0 -> -48
        send_vec("neg", 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, -48);
        take_result("neg", 0);

        // 1.5*2.0 + -2.0*0.5 + 0.25 = 2.25 -> 147456 >>> 12 = 36
        send_vec("mix", 16'h0180, 16'hFE00, 16'h0200, 16'h0080, 16'h0040, 36);
        take_result("mix", 1);

        // Sum of -1 LSB floors to -1, not 0.
        send_vec("floor", 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, -1);
        take_result("floor", 0);

        // Large positive clips to 127.
        send_vec("satpos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 127);
`ifdef NEURON_MAC_SAT_FLAG_EN
        check("satpos_flag", longint'(sat_flag), 1);
`endif
        take_result("satpos", 0);
`ifdef NEURON_MAC_SAT_FLAG_EN
        check("satpos_flag_cleared", longint'(sat_flag), 0);
`endif

        // Large negative clips to -128.
        send_vec("satneg", 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, -128);
        take_result("satneg", 0);

        // Reset after the first beat of a vector abandons it.
        bias = 16'h0000;
        drive_beat(16'h0300, 16'h0100);
        check("mid_busy", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_x", longint'(out_x), 0);
        check("mid_rst_busy", longint'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_vec("after_rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 32);

        // Reset while a result is held drops it immediately.
        #2;
        rst_n = 1'b0;
        expq.delete();
        #1;
        check("hold_rst_valid", longint'(out_valid), 0);
        check("hold_rst_x", longint'(out_x), 0);
        check("hold_rst_busy", longint'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("hold_rst_in_ready", longint'(in_ready), 1);

        send_vec("final", 16'h0200, 16'h0100, 16'h0100, 16'hFF80, 16'h0000, 24);
        take_result("final", 2);

        check("queue_drained", longint'(expq.size()), 0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter dataWidth, default 16, width of signed 8.8 fixed-point data, weight and bias.
REQ-002 SHALL have parameter numInputs, default 2, number of beats (data/weight pairs) per dot product; legal range 1..255.
REQ-003 SHALL have parameter outWidth, default 8, width of signed activation index driven to the downstream sigmoid LUT stage.
REQ-004 SHALL have parameter SHIFT, default 12, arithmetic right-shift applied to the 16.16 sum before saturation.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, dataWidth, signed 8.8 input activation.
REQ-010 SHALL have port in_weight, input, dataWidth, signed 8.8 weight.
REQ-011 SHALL have port bias, input, dataWidth, signed 8.8 bias, sampled in state BIAS.
REQ-012 SHALL have port out_valid, output, 1, out_x holds a valid result.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts out_x.
REQ-014 SHALL have port out_x, output, outWidth, signed saturated pre-activation index.
REQ-015 SHALL have port busy, output, 1, high whenever state is not ACC or beat count is nonzero.

Function
REQ-016 SHALL implement states ACC, BIAS, SAT, HOLD; in_ready SHALL be 1 only in ACC.
REQ-017 In ACC, a beat is accepted when in_valid and in_ready are both 1; acc += sign-extended in_data*in_weight (full 2*dataWidth signed product, accumulator 2*dataWidth+8 bits, no wrap for numInputs<=255).
REQ-018 Beat counter SHALL increment per accepted beat; on the numInputs-th beat, counter SHALL wrap to 0 and state SHALL go to BIAS.
REQ-019 BIAS (one cycle): acc += bias sign-extended and shifted left 8 (aligned to 16.16); next state SAT.
REQ-020 SAT (one cycle): out_x <= acc >>> SHIFT (floor), saturated to [-2^(outWidth-1), 2^(outWidth-1)-1]; out_valid <= 1; next state HOLD.
REQ-021 Latency: out_valid SHALL assert exactly 2 cycles after the edge accepting the last beat.
REQ-022 HOLD: out_x and out_valid SHALL remain stable until out_ready=1; on that edge out_valid <= 0, acc <= 0, state <= ACC.
REQ-023 out_ready while out_valid=0 SHALL have no effect; in_valid outside ACC SHALL be ignored and no beat lost (in_ready=0).
REQ-024 numInputs=1: the single accepted beat SHALL go directly to BIAS.

Reset
REQ-025 rst_n=0 SHALL immediately force state ACC, acc 0, counter 0, out_x 0, out_valid 0, in_ready 1 after release, busy 0, regardless of state (incl. mid-vector or HOLD).
REQ-026 First accepted beat after reset release SHALL be treated as beat 0 of a new vector.

Configuration
REQ-027 Macro NEURON_MAC_SAT_FLAG_EN: when defined, SHALL add output sat_flag (1 bit), set in SAT to 1 iff saturation clipped the result, held with out_x, reset 0, cleared with out_valid; when undefined, port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-028 data 0x0100,0x0100; weights 0x0100,0x0100; bias 0x0000 -> out_x=32 (0x20), out_valid 2 cycles after second beat.
REQ-029 data 0x0100 x2; weights 0xFF00 x2; bias 0xFF00 -> sum -3.0 -> out_x=-48 (0xD0).
REQ-030 data 0x7FFF x2; weights 0x7FFF x2 -> out_x=127 (0x7F); with NEURON_MAC_SAT_FLAG_EN sat_flag=1; data 0x7FFF, weight 0x8000 -> out_x=-128 (0x80).
REQ-031 Hold out_ready=0 for 5 cycles after out_valid -> out_x stable, in_ready=0, in_valid beats not accepted; out_ready=1 -> in_ready=1 next cycle.
REQ-032 Assert rst_n=0 after first beat of a vector -> all outputs 0 immediately; next two beats (0x0100*0x0100 each, bias 0) -> out_x=32.
